pipeline_hazard_ctrl: RTL

//  Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives PC write-enable,
//  IF/ID write-enable and flush, ID/EX bubble insertion and EX/MEM hold.

---
 rtl/mips_pipe_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pipe_pkg;

    // Hazard controller sequencing states.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hz_state_e;

    // Register $0 is hard-wired to zero, so it can never carry a dependency.
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // Encoding loaded into IF/ID when it is flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request, but stick at the all-ones value instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared whenever the pipeline is in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use
// stalls, taken-branch flushes and data-memory freeze, plus stall/flush counters.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Extra flush cycles that follow the branch cycle itself.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    hz_state_e  state_q, state_d;
    logic [2:0] flush_left_q, flush_left_d;
    logic       load_use;

    assign load_use = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    // Next-state and same-cycle control outputs; memory wait beats branch beats load-use.
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;

        if (mem_busy) begin
            // Freeze everything; branch/load-use inputs will be presented again.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else begin
            case (state_q)
                FLUSH: begin
                    if_id_flush = 1'b1;
                    if (ex_branch_taken) begin
                        flush_left_d = FLUSH_RELOAD;
                    end else begin
                        flush_left_d = flush_left_q - 3'd1;
                        if (flush_left_q <= 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    // RUN and LOAD_STALL share outputs; LOAD_STALL never re-stalls.
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_d      = FLUSH;
                            flush_left_d = FLUSH_RELOAD;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (load_use && (state_q == RUN)) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = LOAD_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
            endcase
        end

        // Reset takes effect on the control outputs immediately, not at the next edge.
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_hold  = 1'b0;
        end
    end

    // State and flush down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            flush_left_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (flush_count)
    );

endmodule
